// File: rtl/majority_event_display.sv
// Debounces the 2-of-3 majority detector output, counts qualified rising events modulo 10
// and shows the count on a seven-segment display with an event-hold decimal point.
module majority_event_display #(
  parameter int unsigned DEBOUNCE_CYCLES = 250_000,
  parameter int unsigned HOLD_CYCLES     = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       det_in,
  input  logic       clr,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] count,
  output logic       event_pulse
);

  localparam int unsigned DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    RISE_WAIT = 2'd1,
    HIGH      = 2'd2,
    FALL_WAIT = 2'd3
  } state_t;

  state_t            state, state_d;
  logic [DEB_W-1:0]  deb_cnt, deb_cnt_d;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_d;
  logic [3:0]        count_d;
  logic [6:0]        seg_d;
  logic              sync1, s;
  logic              fire;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h40;
    endcase
  endfunction

  // Two-flop synchroniser keeps sampling even while disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= det_in;
      s     <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= LOW;
      deb_cnt <= '0;
    end else begin
      state   <= state_d;
      deb_cnt <= deb_cnt_d;
    end
  end

  // Debounce next-state; a qualified rise fires exactly once on RISE_WAIT -> HIGH.
  always_comb begin
    state_d   = state;
    deb_cnt_d = deb_cnt;
    fire      = 1'b0;
    if (en) begin
      case (state)
        LOW: begin
          if (s) begin
            state_d   = RISE_WAIT;
            deb_cnt_d = '0;
          end
        end
        RISE_WAIT: begin
          if (!s) begin
            state_d = LOW;
          end else if (deb_cnt == DEB_LAST) begin
            state_d = HIGH;
            fire    = 1'b1;
          end else begin
            deb_cnt_d = deb_cnt + DEB_W'(1);
          end
        end
        HIGH: begin
          if (!s) begin
            state_d   = FALL_WAIT;
            deb_cnt_d = '0;
          end
        end
        FALL_WAIT: begin
          if (s) begin
            state_d = HIGH;
          end else if (deb_cnt == DEB_LAST) begin
            state_d = LOW;
          end else begin
            deb_cnt_d = deb_cnt + DEB_W'(1);
          end
        end
        default: state_d = LOW;
      endcase
    end
  end

  // Counter and hold-window next values; clear beats a coincident event.
  always_comb begin
    count_d    = count;
    hold_cnt_d = (hold_cnt != '0) ? hold_cnt - HOLD_W'(1) : '0;
    if (fire) begin
      count_d    = (count == 4'd9) ? 4'd0 : count + 4'd1;
      hold_cnt_d = HOLD_LOAD;
    end
    if (clr) begin
      count_d    = 4'd0;
      hold_cnt_d = '0;
    end
    seg_d = seg_decode(count_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= 4'd0;
      hold_cnt    <= '0;
      seg         <= 7'h3F;
      dp          <= 1'b0;
      event_pulse <= 1'b0;
    end else if (!en) begin
      seg         <= 7'h00;
      dp          <= 1'b0;
      event_pulse <= 1'b0;
    end else begin
      count       <= count_d;
      hold_cnt    <= hold_cnt_d;
      seg         <= seg_d;
      dp          <= (hold_cnt_d != '0);
      event_pulse <= fire;
    end
  end

endmodule

// File: tb/tb_majority_event_display.sv
// Directed self-checking bench for majority_event_display (DEBOUNCE_CYCLES=4, HOLD_CYCLES=8),
// with a second HOLD_CYCLES=16 instance to observe dp retriggering inside the hold window.
module tb_majority_event_display;

  logic       clk = 1'b0;
  logic       rst, en, det_in, clr;
  logic [6:0] seg, seg_l;
  logic       dp, dp_l;
  logic [3:0] count, count_l;
  logic       event_pulse, event_pulse_l;

  int checks   = 0;
  int failures = 0;

  logic [6:0] seg_tab [10];

  majority_event_display #(.DEBOUNCE_CYCLES(4), .HOLD_CYCLES(8)) u_dut (
    .clk(clk), .rst(rst), .en(en), .det_in(det_in), .clr(clr),
    .seg(seg), .dp(dp), .count(count), .event_pulse(event_pulse)
  );

  majority_event_display #(.DEBOUNCE_CYCLES(4), .HOLD_CYCLES(16)) u_dut_long (
    .clk(clk), .rst(rst), .en(en), .det_in(det_in), .clr(clr),
    .seg(seg_l), .dp(dp_l), .count(count_l), .event_pulse(event_pulse_l)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clean debounced event followed by a full debounced fall back to LOW.
  task automatic do_event(input logic [3:0] exp_count, input bit chk_long);
    det_in = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("ev_pre", 32'(event_pulse), 32'd0);
      if (chk_long) chk("dp_long_rise", 32'(dp_l), 32'd1);
    end
    tick();
    chk("ev_fire", 32'(event_pulse), 32'd1);
    chk("ev_count", 32'(count), 32'(exp_count));
    chk("ev_seg", 32'(seg), 32'(seg_tab[exp_count]));
    chk("ev_dp", 32'(dp), 32'd1);
    chk("ev_dp_long", 32'(dp_l), 32'd1);
    det_in = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk("dp_long_fall", 32'(dp_l), 32'd1);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    rst = 1'b1; en = 1'b1; det_in = 1'b0; clr = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_seg", 32'(seg), 32'h3F);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_dp", 32'(dp), 32'd0);
    chk("rst_ev", 32'(event_pulse), 32'd0);
    rst = 1'b0;

    // Clean edge: pulse in cycle 7, dp high cycles 7..14
    det_in = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("clean_ev", 32'(event_pulse), (i == 7) ? 32'd1 : 32'd0);
      chk("clean_dp", 32'(dp), (i >= 7 && i <= 14) ? 32'd1 : 32'd0);
      if (i >= 7) begin
        chk("clean_count", 32'(count), 32'd1);
        chk("clean_seg", 32'(seg), 32'h06);
      end
    end
    det_in = 1'b0;
    repeat (8) tick();

    // Bounce shorter than the debounce window
    pulse_reset();
    begin
      logic [6:0] pat;
      pat = 7'b0110111;
      for (int i = 0; i < 7; i++) begin
        det_in = pat[i];
        tick();
        chk("bounce_ev", 32'(event_pulse), 32'd0);
      end
    end
    det_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("bounce_ev_tail", 32'(event_pulse), 32'd0);
    end
    chk("bounce_count", 32'(count), 32'd0);

    // Two-cycle glitch low while HIGH yields no second event
    det_in = 1'b1;
    repeat (6) tick();
    tick();
    chk("glitch_first_ev", 32'(event_pulse), 32'd1);
    repeat (2) tick();
    det_in = 1'b0;
    repeat (2) tick();
    det_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("glitch_ev", 32'(event_pulse), 32'd0);
    end
    chk("glitch_count", 32'(count), 32'd1);
    det_in = 1'b0;
    repeat (8) tick();

    // Wrap through ten events; long-hold instance stays lit throughout
    pulse_reset();
    for (int n = 1; n <= 10; n++) begin
      do_event(4'(n % 10), n > 1);
    end
    chk("wrap_count", 32'(count), 32'd0);
    chk("wrap_seg", 32'(seg), 32'h3F);
    for (int i = 9; i <= 17; i++) begin
      tick();
      chk("retrig_dp_long", 32'(dp_l), (i <= 16) ? 32'd1 : 32'd0);
      chk("retrig_dp", 32'(dp), 32'd0);
    end

    // clr coincident with the event edge at count=5
    for (int n = 1; n <= 5; n++) begin
      do_event(4'(n), n > 1);
    end
    det_in = 1'b1;
    repeat (6) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_ev", 32'(event_pulse), 32'd1);
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_seg", 32'(seg), 32'h3F);
    chk("clr_dp", 32'(dp), 32'd0);
    det_in = 1'b0;
    repeat (8) tick();

    // Disable mid-RISE_WAIT (deb_cnt=1), then resume
    det_in = 1'b1;
    repeat (4) tick();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("dis_seg", 32'(seg), 32'd0);
      chk("dis_dp", 32'(dp), 32'd0);
      chk("dis_ev", 32'(event_pulse), 32'd0);
      chk("dis_count", 32'(count), 32'd0);
    end
    en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("resume_ev", 32'(event_pulse), (i == 3) ? 32'd1 : 32'd0);
    end
    chk("resume_count", 32'(count), 32'd1);
    chk("resume_seg", 32'(seg), 32'h06);
    chk("resume_dp", 32'(dp), 32'd1);

    // Reset in the middle of the hold window
    tick();
    tick();
    chk("midhold_dp", 32'(dp), 32'd1);
    rst = 1'b1;
    tick();
    chk("midrst_seg", 32'(seg), 32'h3F);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_dp", 32'(dp), 32'd0);
    chk("midrst_ev", 32'(event_pulse), 32'd0);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
